pipeline_ctrl: RTL and testbench

Parametrised control unit for the 3-stage D/X/W RISC-V pipeline. It decodes the RV32I opcode and funct fields in D into a control bundle and carries that bundle through pipeline registers to X and W. It also generates stall, flush and forwarding selects and keeps cycle and retired-instruction counters. It sits beside the datapath and drives every mux select, write-enable and pipeline-register enable.

---
 rtl/pipeline_ctrl_pkg.sv | 84 ++++++++
 rtl/pipeline_ctrl_decoder.sv | 91 +++++++++
 rtl/pipeline_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings, control bundle type and helpers
// for the D/X/W pipeline control unit.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
  localparam logic [3:0] ALU_PASS_A = 4'd11;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       a_sel;
    logic       b_sel;
    logic [2:0] imm_sel;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       csr_we;
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic src_hit(input logic [4:0] rs, input ctrl_t producer);
    return (rs != 5'd0) && producer.reg_we && (producer.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_decoder.sv
// rtl/pipeline_ctrl_decoder.sv - combinational RV32I decoder, instruction word
// to control bundle; unused register fields are zeroed so they never alias a hazard.
module inst_decoder
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    ctrl       = CTRL_BUBBLE;
    illegal    = 1'b0;
    ctrl.valid = 1'b1;
    ctrl.rd    = inst[11:7];
    ctrl.rs1   = inst[19:15];
    ctrl.rs2   = inst[24:20];
    case (opcode)
      OP_LUI: begin
        ctrl.rs1 = 5'd0; ctrl.rs2 = 5'd0;
        ctrl.alu_op = ALU_PASS_B; ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_U;
        ctrl.reg_we = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.rs1 = 5'd0; ctrl.rs2 = 5'd0;
        ctrl.a_sel = 1'b1; ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_U;
        ctrl.reg_we = 1'b1;
      end
      OP_JAL: begin
        ctrl.rs1 = 5'd0; ctrl.rs2 = 5'd0;
        ctrl.a_sel = 1'b1; ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_J;
        ctrl.jal = 1'b1; ctrl.wb_sel = WB_PC4; ctrl.reg_we = 1'b1;
      end
      OP_JALR: begin
        ctrl.rs2 = 5'd0;
        ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_I;
        ctrl.jalr = 1'b1; ctrl.wb_sel = WB_PC4; ctrl.reg_we = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.rd = 5'd0;
        ctrl.a_sel = 1'b1; ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_B;
        ctrl.br = 1'b1;
      end
      OP_LOAD: begin
        ctrl.rs2 = 5'd0;
        ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_I;
        ctrl.mem_rd = 1'b1; ctrl.wb_sel = WB_MEM; ctrl.reg_we = 1'b1;
      end
      OP_STORE: begin
        ctrl.rd = 5'd0;
        ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_S;
        ctrl.mem_wr = 1'b1;
      end
      OP_IMM: begin
        ctrl.rs2 = 5'd0;
        ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_I;
        ctrl.alu_op = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
        ctrl.reg_we = 1'b1;
      end
      OP_OP: begin
        ctrl.alu_op = alu_decode(funct3, funct7[5]);
        ctrl.reg_we = 1'b1;
        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_SYSTEM: begin
        ctrl.rs2 = 5'd0;
        ctrl.csr_we = 1'b1; ctrl.reg_we = 1'b1; ctrl.wb_sel = WB_CSR;
        if (funct3 == 3'b001) begin
          ctrl.alu_op = ALU_PASS_A;
        end else if (funct3 == 3'b101) begin
          // csrrwi carries zimm in the rs1 field, so it has no register source
          ctrl.rs1 = 5'd0;
          ctrl.alu_op = ALU_PASS_B; ctrl.b_sel = 1'b1; ctrl.imm_sel = IMM_Z;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = CTRL_BUBBLE;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - D/X/W pipeline control: decode, control pipeline
// registers, stall/flush/forward generation and performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  inst_d,
  input  logic             inst_valid_d,
  input  logic             br_taken_x,
  input  logic             mem_ready,
  output ctrl_t            ctrl_x,
  output ctrl_t            ctrl_w,
  output logic             fwd_a_x,
  output logic             fwd_b_x,
  output logic             stall_d,
  output logic             flush_d,
  output logic             redirect,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_x_next;
  logic  dec_illegal;
  logic  mem_freeze;
  logic  raw;

  inst_decoder u_dec (
    .inst    (inst_d[31:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign mem_freeze = ctrl_w.valid & (ctrl_w.mem_rd | ctrl_w.mem_wr) & ~mem_ready;

  // A taken control transfer waits in X until any memory freeze releases.
  assign redirect = ~mem_freeze & ctrl_x.valid &
                    (ctrl_x.jal | ctrl_x.jalr | (ctrl_x.br & br_taken_x));
  assign flush_d  = redirect;

  generate
    if (FWD_EN) begin : g_fwd
      assign fwd_a_x = ctrl_w.reg_we & (ctrl_w.rd != 5'd0) & (ctrl_w.rd == ctrl_x.rs1);
      assign fwd_b_x = ctrl_w.reg_we & (ctrl_w.rd != 5'd0) & (ctrl_w.rd == ctrl_x.rs2);
      assign raw     = 1'b0;
    end else begin : g_stall
      assign fwd_a_x = 1'b0;
      assign fwd_b_x = 1'b0;
      assign raw     = inst_valid_d &
                       (src_hit(dec_ctrl.rs1, ctrl_x) | src_hit(dec_ctrl.rs2, ctrl_x) |
                        src_hit(dec_ctrl.rs1, ctrl_w) | src_hit(dec_ctrl.rs2, ctrl_w));
    end
  endgenerate

  assign stall_d     = mem_freeze | (raw & ~redirect);
  assign ctrl_x_next = (inst_valid_d & ~redirect & ~raw) ? dec_ctrl : CTRL_BUBBLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_x      <= CTRL_BUBBLE;
      ctrl_w      <= CTRL_BUBBLE;
      illegal     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (!mem_freeze) begin
        ctrl_x <= ctrl_x_next;
        ctrl_w <= ctrl_x;
        if (ctrl_w.valid) instret_cnt <= instret_cnt + CNT_W'(1);
      end
      // Only an instruction that actually advances out of D may raise illegal.
      if (inst_valid_d & dec_illegal & ~mem_freeze & ~redirect) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed bench for pipeline_ctrl, forwarding and
// stalling builds side by side, with a retire scoreboard.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD2  = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] I_ADDI3 = 32'h0010_0193;  // addi x3,x0,1
  localparam logic [31:0] I_BEQ   = 32'h0000_0463;  // beq  x0,x0,+8
  localparam logic [31:0] I_LW5   = 32'h0000_2283;  // lw   x5,0(x0)
  localparam logic [31:0] I_JAL1  = 32'h0080_00EF;  // jal  x1,+8
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_d;
  logic        inst_valid_d;
  logic        br_taken_x;
  logic        mem_ready;

  ctrl_t       f_ctrl_x, f_ctrl_w, s_ctrl_x, s_ctrl_w;
  logic        f_fwd_a, f_fwd_b, f_stall, f_flush, f_redir, f_illegal;
  logic        s_fwd_a, s_fwd_b, s_stall, s_flush, s_redir, s_illegal;
  logic [31:0] f_cycle, f_instret, s_cycle, s_instret;

  int          n_chk = 0;
  int          n_pass = 0;
  int          sel = 0;
  logic [7:0]  sb[$];

  pipeline_ctrl #(.XLEN(32), .CNT_W(32), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .inst_valid_d(inst_valid_d),
    .br_taken_x(br_taken_x), .mem_ready(mem_ready),
    .ctrl_x(f_ctrl_x), .ctrl_w(f_ctrl_w), .fwd_a_x(f_fwd_a), .fwd_b_x(f_fwd_b),
    .stall_d(f_stall), .flush_d(f_flush), .redirect(f_redir), .illegal(f_illegal),
    .cycle_cnt(f_cycle), .instret_cnt(f_instret)
  );

  pipeline_ctrl #(.XLEN(32), .CNT_W(32), .FWD_EN(1'b0)) u_stl (
    .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .inst_valid_d(inst_valid_d),
    .br_taken_x(br_taken_x), .mem_ready(mem_ready),
    .ctrl_x(s_ctrl_x), .ctrl_w(s_ctrl_w), .fwd_a_x(s_fwd_a), .fwd_b_x(s_fwd_b),
    .stall_d(s_stall), .flush_d(s_flush), .redirect(s_redir), .illegal(s_illegal),
    .cycle_cnt(s_cycle), .instret_cnt(s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tag(input logic we, input logic [1:0] wb, input logic [4:0] rd);
    return {we, wb, rd};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  // Retire monitor on the selected build, then advance one clock.
  task automatic step();
    ctrl_t w;
    logic  frz;
    logic [7:0] exp_tag;
    w   = (sel != 0) ? s_ctrl_w : f_ctrl_w;
    frz = w.valid & (w.mem_rd | w.mem_wr) & ~mem_ready;
    if (w.valid && !frz) begin
      chk("retire_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        exp_tag = sb.pop_front();
        chk("retire_tag", 64'({w.reg_we, w.wb_sel, w.rd}), 64'(exp_tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_d = 32'h0;
    inst_valid_d = 1'b0;
    br_taken_x = 1'b0;
    mem_ready = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    rst_n = 1'b0; inst_d = 32'h0; inst_valid_d = 1'b0; br_taken_x = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ctrl_x", 64'(f_ctrl_x), 64'(0));
    chk("rst_ctrl_w", 64'(f_ctrl_w), 64'(0));
    chk("rst_fwd", 64'({f_fwd_a, f_fwd_b}), 64'(0));
    chk("rst_stall_flush_redir", 64'({f_stall, f_flush, f_redir}), 64'(0));
    chk("rst_illegal", 64'(f_illegal), 64'(0));
    chk("rst_cycle", 64'(f_cycle), 64'(0));
    chk("rst_instret", 64'(f_instret), 64'(0));
    rst_n = 1'b1;
    repeat (5) step();
    chk("cycle_after_5", 64'(f_cycle), 64'(5));
    chk("instret_idle", 64'(f_instret), 64'(0));

    // forwarding build: addi then dependent add
    sel = 0;
    do_reset();
    inst_d = I_ADDI1; inst_valid_d = 1'b1; sb.push_back(tag(1'b1, WB_ALU, 5'd1));
    step();
    inst_d = I_ADD2; sb.push_back(tag(1'b1, WB_ALU, 5'd2));
    #1 chk("fwd_no_stall_d", 64'(f_stall), 64'(0));
    step();
    inst_valid_d = 1'b0;
    #1 chk("fwd_a_x", 64'(f_fwd_a), 64'(1));
    chk("fwd_b_x", 64'(f_fwd_b), 64'(1));
    chk("fwd_no_stall_x", 64'(f_stall), 64'(0));
    step(); step(); step();
    chk("fwd_sb_drained", 64'(sb.size()), 64'(0));
    chk("fwd_instret", 64'(f_instret), 64'(2));

    // stalling build: same pair, add sees 2 stall cycles and retires on its cycle 5
    sel = 1;
    do_reset();
    inst_d = I_ADDI1; inst_valid_d = 1'b1; sb.push_back(tag(1'b1, WB_ALU, 5'd1));
    step();
    inst_d = I_ADD2; sb.push_back(tag(1'b1, WB_ALU, 5'd2));
    #1 chk("raw_stall_c1", 64'(s_stall), 64'(1));
    step();
    #1 chk("raw_stall_c2", 64'(s_stall), 64'(1));
    chk("raw_bubble_c2", 64'(s_ctrl_x), 64'(0));
    step();
    #1 chk("raw_stall_c3", 64'(s_stall), 64'(0));
    chk("raw_bubble_c3", 64'(s_ctrl_x), 64'(0));
    step();
    inst_valid_d = 1'b0;
    #1 chk("raw_add_in_x", 64'({s_ctrl_x.valid, s_ctrl_x.rd}), 64'({1'b1, 5'd2}));
    chk("raw_fwd_tied", 64'({s_fwd_a, s_fwd_b}), 64'(0));
    step();
    #1 chk("raw_add_in_w_c5", 64'({s_ctrl_w.valid, s_ctrl_w.rd}), 64'({1'b1, 5'd2}));
    step(); step();
    chk("raw_sb_drained", 64'(sb.size()), 64'(0));
    chk("raw_instret", 64'(s_instret), 64'(2));

    // taken branch: one-cycle redirect, shadow instruction squashed
    sel = 0;
    do_reset();
    inst_d = I_BEQ; inst_valid_d = 1'b1; sb.push_back(tag(1'b0, WB_ALU, 5'd0));
    step();
    inst_d = I_ADDI3; br_taken_x = 1'b1;
    #1 chk("br_redirect", 64'({f_redir, f_flush}), 64'(2'b11));
    step();
    br_taken_x = 1'b0; inst_valid_d = 1'b0;
    #1 chk("br_redirect_once", 64'({f_redir, f_flush}), 64'(0));
    chk("br_bubble_x", 64'(f_ctrl_x), 64'(0));
    step(); step(); step();
    chk("br_instret", 64'(f_instret), 64'(1));
    chk("br_sb_drained", 64'(sb.size()), 64'(0));

    // load in W frozen 3 cycles with a taken jal waiting in X
    do_reset();
    inst_d = I_LW5; inst_valid_d = 1'b1; sb.push_back(tag(1'b1, WB_MEM, 5'd5));
    step();
    inst_d = I_JAL1; sb.push_back(tag(1'b1, WB_PC4, 5'd1));
    step();
    inst_d = I_ADDI3; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_no_redirect", 64'(f_redir), 64'(0));
      chk("frz_stall", 64'(f_stall), 64'(1));
      chk("frz_hold_x", 64'({f_ctrl_x.valid, f_ctrl_x.jal}), 64'(2'b11));
      chk("frz_hold_w", 64'({f_ctrl_w.valid, f_ctrl_w.mem_rd}), 64'(2'b11));
      chk("frz_instret", 64'(f_instret), 64'(0));
      step();
    end
    mem_ready = 1'b1;
    #1 chk("frz_release_redirect", 64'({f_redir, f_flush}), 64'(2'b11));
    step();
    inst_valid_d = 1'b0;
    #1 chk("frz_instret_once", 64'(f_instret), 64'(1));
    chk("frz_jal_in_w", 64'(f_ctrl_w.jal), 64'(1));
    chk("frz_shadow_bubble", 64'(f_ctrl_x), 64'(0));
    step(); step();
    chk("frz_instret_final", 64'(f_instret), 64'(2));
    chk("frz_sb_drained", 64'(sb.size()), 64'(0));

    // illegal opcode is sticky until reset
    do_reset();
    inst_d = I_BAD; inst_valid_d = 1'b1;
    #1 chk("ill_pre", 64'(f_illegal), 64'(0));
    step();
    inst_valid_d = 1'b0;
    #1 chk("ill_set", 64'(f_illegal), 64'(1));
    chk("ill_bubble_x", 64'(f_ctrl_x), 64'(0));
    step(); step(); step();
    chk("ill_sticky", 64'(f_illegal), 64'(1));
    chk("ill_no_retire", 64'(f_instret), 64'(0));
    rst_n = 1'b0;
    #1 chk("ill_async_clear", 64'(f_illegal), 64'(0));
    chk("ill_async_cycle", 64'(f_cycle), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
